dcache_dm: RTL and testbench

- Direct-mapped, write-through, no-write-allocate data cache between the core's load/store port and a slower backing data memory.
- Replaces the single-cycle, zero-latency data memory path. The core holds its request while cpu_stall is high.
- Parametrised in data width, address width, number of lines and words per line.
- Backing side uses a req/ack handshake with variable latency.

---
 rtl/dcache_dm_if.sv | 32 +++
 rtl/dcache_dm.sv | 173 +++++++++++++++++
 tb/tb_dcache_dm.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_dm_if.sv
// rtl/dcache_dm_if.sv - core load/store port and backing-memory bus for dcache_dm
interface dcache_dm_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                    cpu_req;
    logic                    cpu_we;
    logic [DATA_WIDTH/8-1:0] cpu_be;
    logic [ADDR_WIDTH-1:0]   cpu_addr;
    logic [DATA_WIDTH-1:0]   cpu_wdata;
    logic [DATA_WIDTH-1:0]   cpu_rdata;
    logic                    cpu_stall;
    logic                    mem_req;
    logic                    mem_we;
    logic [DATA_WIDTH/8-1:0] mem_be;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [DATA_WIDTH-1:0]   mem_rdata;
    logic                    mem_ack;

    // Cache side
    modport slave (
        input  cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
        output cpu_rdata, cpu_stall, mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );

    // Core plus backing memory side
    modport master (
        output cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
        input  cpu_rdata, cpu_stall, mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dcache_dm.sv
// rtl/dcache_dm.sv - direct-mapped write-through no-write-allocate data cache (optional DCACHE_STATS_EN)
module dcache_dm #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_LINES  = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic        CLK,
    input  logic        RST,
    dcache_dm_if.slave  bus
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int BB    = (BYTES > 1) ? $clog2(BYTES) : 0;
    localparam int OB    = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 0;
    localparam int IB    = $clog2(NUM_LINES);
    localparam int TB    = ADDR_WIDTH - BB - OB - IB;
    localparam int CW    = (OB > 0) ? OB : 1;
    localparam int PW    = $clog2(NUM_LINES * LINE_WORDS);

    typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] data_q [NUM_LINES*LINE_WORDS];
    logic [TB-1:0]         tag_q  [NUM_LINES];
    logic [NUM_LINES-1:0]  valid_q;
    logic [CW-1:0]         cnt_q;

    logic                  mem_req_q;
    logic                  mem_we_q;
    logic [BYTES-1:0]      mem_be_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;

    logic [TB-1:0]         req_tag;
    logic [IB-1:0]         req_idx;
    logic [CW-1:0]         req_off;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic [ADDR_WIDTH-1:0] line_base;
    logic [PW-1:0]         hit_ptr;
    logic [PW-1:0]         fill_ptr;
    logic                  hit;
    logic                  ack_v;
    logic                  last_word;
    logic [CW-1:0]         cnt_next;

    logic                  stall_c;
    logic [DATA_WIDTH-1:0] rdata_c;

    assign req_tag   = bus.cpu_addr[ADDR_WIDTH-1 -: TB];
    assign req_idx   = bus.cpu_addr[BB+OB +: IB];
    assign req_off   = CW'(bus.cpu_addr >> BB) & CW'(LINE_WORDS - 1);
    assign word_addr = bus.cpu_addr & ~ADDR_WIDTH'(BYTES - 1);
    assign line_base = bus.cpu_addr & ~ADDR_WIDTH'(LINE_WORDS * BYTES - 1);
    assign hit_ptr   = (PW'(req_idx) << OB) | PW'(req_off);
    assign fill_ptr  = (PW'(req_idx) << OB) | PW'(cnt_q);
    assign hit       = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign ack_v     = bus.mem_ack && mem_req_q;
    assign last_word = (cnt_q == CW'(LINE_WORDS - 1));
    assign cnt_next  = last_word ? '0 : CW'(cnt_q + 1'b1);

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.cpu_stall = stall_c;
    assign bus.cpu_rdata = rdata_c;

    // Stall and hit data are combinational so a load hit costs no extra cycle
    always_comb begin
        stall_c = 1'b0;
        rdata_c = '0;
        case (state)
            IDLE: begin
                if (bus.cpu_req) begin
                    if (bus.cpu_we || !hit) stall_c = 1'b1;
                    else                    rdata_c = data_q[hit_ptr];
                end
            end
            REFILL:  stall_c = 1'b1;
            WRITE:   stall_c = !ack_v;
            default: stall_c = 1'b0;
        endcase
    end

    // Control FSM: owns valid bits, refill counter and the registered backing bus
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            valid_q     <= '0;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cpu_req && bus.cpu_we) begin
                        state       <= WRITE;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_be_q    <= bus.cpu_be;
                        mem_addr_q  <= word_addr;
                        mem_wdata_q <= bus.cpu_wdata;
                    end else if (bus.cpu_req && !hit) begin
                        // Line is invalid until the whole refill lands, so an abort leaves no stale words visible
                        state            <= REFILL;
                        valid_q[req_idx] <= 1'b0;
                        cnt_q            <= '0;
                        mem_req_q        <= 1'b1;
                        mem_we_q         <= 1'b0;
                        mem_be_q         <= '1;
                        mem_addr_q       <= line_base;
                    end
                end
                REFILL: begin
                    if (ack_v) begin
                        cnt_q <= cnt_next;
                        if (last_word) begin
                            state            <= IDLE;
                            valid_q[req_idx] <= 1'b1;
                            mem_req_q        <= 1'b0;
                        end else begin
                            mem_addr_q <= line_base | (ADDR_WIDTH'(cnt_next) << BB);
                        end
                    end
                end
                WRITE: begin
                    if (ack_v) begin
                        state     <= IDLE;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Data and tag arrays: refill words on read acks, merge store bytes on a write ack that hits
    always_ff @(posedge CLK) begin
        if (!RST && ack_v) begin
            if (state == REFILL) begin
                data_q[fill_ptr] <= bus.mem_rdata;
                if (last_word) tag_q[req_idx] <= req_tag;
            end else if (state == WRITE && hit) begin
                for (int b = 0; b < BYTES; b++) begin
                    if (bus.cpu_be[b]) data_q[hit_ptr][b*8 +: 8] <= bus.cpu_wdata[b*8 +: 8];
                end
            end
        end
    end

`ifdef DCACHE_STATS_EN
    // Hit/miss counters; the hit that completes a refilled load is counted as a hit too
    always_ff @(posedge CLK) begin
        if (RST) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == IDLE && bus.cpu_req && !bus.cpu_we) begin
            if (hit) hit_count  <= hit_count + 32'd1;
            else     miss_count <= miss_count + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_dcache_dm.sv
// tb/tb_dcache_dm.sv - self-checking bench for dcache_dm against a behavioural memory/cache model
module tb_dcache_dm;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int NL = 16;
    localparam int LW = 4;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    dcache_dm_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    dcache_dm #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_LINES(NL), .LINE_WORDS(LW)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count(hit_count),
        .miss_count(miss_count)
`endif
    );

    int errors = 0;
    int checks = 0;

    // Backing memory: the single source of truth for every word (write-through keeps it current)
    logic [31:0] bmem [int unsigned];
    // Which line each index currently holds, by the cache rules
    bit          mvalid [NL];
    logic [31:0] mtag   [NL];
    int          m_hits   = 0;
    int          m_misses = 0;

    int lat_fixed = 2;
    int wait_cnt  = 0;
    bit force_ack = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        int unsigned k;
        k = a >> 2;
        if (!bmem.exists(k)) bmem[k] = $urandom;
        return bmem[k];
    endfunction

    function automatic int next_lat();
        return (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 3));
    endfunction

    // Backing memory responder with variable latency
    initial begin
        logic [31:0] w;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge CLK);
            #1;
            bus.mem_ack = 1'b0;
            if (force_ack) begin
                bus.mem_ack = 1'b1;
            end else if (RST || !bus.mem_req) begin
                wait_cnt = next_lat();
            end else if (wait_cnt > 0) begin
                wait_cnt--;
            end else begin
                bus.mem_ack = 1'b1;
                w = mem_word(bus.mem_addr);
                if (bus.mem_we) begin
                    for (int b = 0; b < 4; b++)
                        if (bus.mem_be[b]) w[b*8 +: 8] = bus.mem_wdata[b*8 +: 8];
                    bmem[bus.mem_addr >> 2] = w;
                end else begin
                    bus.mem_rdata = w;
                end
                wait_cnt = next_lat();
            end
        end
    end

    // Compare process: load data versus backing memory, and backing-bus stability while waiting
    logic        p_req = 1'b0;
    logic        p_ack = 1'b0;
    logic [68:0] p_bus = '0;
    always @(negedge CLK) begin
        if (!RST) begin
            if (bus.cpu_req && !bus.cpu_we && !bus.cpu_stall)
                check("load_data", bus.cpu_rdata, mem_word(bus.cpu_addr));
            if (p_req && !p_ack && bus.mem_req)
                check("mem_stable", {bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata}, p_bus);
        end
        p_req = bus.mem_req && !RST;
        p_ack = bus.mem_ack;
        p_bus = {bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata};
    end

    // One core access: held until cpu_stall drops; checks backing traffic against the model
    task automatic access(input bit we, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wdata, output logic [31:0] rdata, output int nrd);
        int          idx;
        logic [31:0] tag;
        logic [31:0] base;
        bit          miss;
        int          nwr;
        int          cyc;
        int          last_ack;
        idx      = int'((addr >> 4) % NL);
        tag      = addr >> 8;
        base     = addr & ~32'hF;
        miss     = !we && !(mvalid[idx] && mtag[idx] == tag);
        nrd      = 0;
        nwr      = 0;
        cyc      = 0;
        last_ack = 0;
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = addr;
        bus.cpu_be    = be;
        bus.cpu_wdata = wdata;
        forever begin
            @(negedge CLK);
            cyc++;
            if (bus.mem_req && bus.mem_ack) begin
                if (we) begin
                    check("wr_fields", {bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata},
                          {1'b1, be, addr & ~32'h3, wdata});
                    nwr++;
                end else begin
                    check("rd_addr", {bus.mem_we, bus.mem_addr}, {1'b0, base + 32'(4 * nrd)});
                    nrd++;
                    last_ack = cyc;
                end
            end
            if (!bus.cpu_stall) break;
            if (cyc > 100) begin
                check("timeout", 1, 0);
                break;
            end
        end
        rdata = bus.cpu_rdata;
        check("rd_count", nrd, miss ? LW : 0);
        check("wr_count", nwr, we ? 1 : 0);
        if (miss)     check("miss_release", cyc - last_ack, 1);
        else if (!we) check("hit_latency", cyc, 1);
        if (miss) begin
            mvalid[idx] = 1'b1;
            mtag[idx]   = tag;
            m_misses++;
        end
        if (!we) m_hits++;
        @(posedge CLK);
        #1;
        bus.cpu_req = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NL; i++) mvalid[i] = 1'b0;
        m_hits   = 0;
        m_misses = 0;
    endtask

    initial begin
        logic [31:0] rd;
        int          n;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_be    = '0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        model_reset();
        for (int k = 0; k < 4; k++) bmem[(32'h100 >> 2) + k] = 32'hA0 + k;

        RST = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("reset_outputs", {bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata,
                                bus.cpu_rdata, bus.cpu_stall}, '0);
        @(posedge CLK);
        #1;
        RST = 1'b0;

        // Cold load, then a hit in the same line
        access(1'b0, 32'h100, 4'h0, 32'h0, rd, n);
        check("cold_data", rd, 32'hA0);
        check("cold_reads", n, 4);
        access(1'b0, 32'h108, 4'h0, 32'h0, rd, n);
        check("hit_data", rd, 32'hA2);
        check("hit_reads", n, 0);

        // Store hit merges low bytes into the cached word
        access(1'b1, 32'h104, 4'b0011, 32'h0000BEEF, rd, n);
        access(1'b0, 32'h104, 4'h0, 32'h0, rd, n);
        check("store_hit_data", rd, 32'h0000BEEF);
        check("store_hit_reads", n, 0);
`ifdef DCACHE_STATS_EN
        check("stats_miss_early", miss_count, 32'd1);
        check("stats_hit_early", hit_count, 32'd3);
`endif

        // Store miss does not allocate
        access(1'b1, 32'h400, 4'hF, 32'h12345678, rd, n);
        access(1'b0, 32'h400, 4'h0, 32'h0, rd, n);
        check("store_miss_reads", n, 4);
        check("store_miss_data", rd, 32'h12345678);

        // Conflicting lines on index 0 evict each other
        access(1'b0, 32'h100, 4'h0, 32'h0, rd, n);
        check("conflict_a_reads", n, 4);
        check("conflict_a_data", rd, 32'hA0);
        access(1'b0, 32'h500, 4'h0, 32'h0, rd, n);
        check("conflict_b_reads", n, 4);
        access(1'b0, 32'h100, 4'h0, 32'h0, rd, n);
        check("conflict_c_reads", n, 4);

        // Reset after the second refill ack, then a stray ack while idle
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 32'h200;
        n = 0;
        for (int c = 0; c < 100 && n < 2; c++) begin
            @(negedge CLK);
            if (bus.mem_req && bus.mem_ack && !bus.mem_we) n++;
        end
        check("rst_two_acks", n, 2);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        bus.cpu_req = 1'b0;
        @(negedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        check("rst_mem_req", bus.mem_req, 1'b0);
        #1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        model_reset();
        force_ack = 1'b1;
        @(posedge CLK);
        #1;
        force_ack = 1'b0;
        @(negedge CLK);
        check("stray_ack", {bus.mem_req, bus.cpu_stall}, 2'b00);
        @(posedge CLK);
        #1;
        access(1'b0, 32'h200, 4'h0, 32'h0, rd, n);
        check("rst_refill_reads", n, 4);

        // Randomised traffic over a few indices and tags
        lat_fixed = -1;
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            bit          w;
            a = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 4) | ($urandom_range(0, 3) << 2);
            w = ($urandom_range(0, 2) == 0);
            access(w, a, ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom), $urandom, rd, n);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge CLK);
                #1;
            end
        end

`ifdef DCACHE_STATS_EN
        check("stats_miss", miss_count, 32'(m_misses));
        check("stats_hit", hit_count, 32'(m_hits));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
